// File: rtl/channel_waveform_decoder_pkg.sv
// Audio widths shared by the channel generators and the waveform decoder,
// so both sides of the sample bus always agree on sizes.
package channel_waveform_decoder_pkg;

    localparam int AUDIO_SAMPLE_WIDTH = 9;
    localparam int AUDIO_PERIOD_WIDTH = 24;

endpackage

// File: rtl/channel_waveform_decoder_running_min_max.sv
// Running minimum/maximum tracker over an unsigned sample stream; restart seeds
// both extremes with the current sample, update folds the sample into them.
module channel_waveform_decoder_running_min_max
    import channel_waveform_decoder_pkg::*;
#(
    parameter int WIDTH = AUDIO_SAMPLE_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_restart,
    input  logic             i_update,
    input  logic [WIDTH-1:0] i_sample,
    output logic [WIDTH-1:0] o_min,
    output logic [WIDTH-1:0] o_max
);

    // Restart takes priority so a new window never inherits the old extremes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_min <= '0;
            o_max <= '0;
        end else if (i_restart) begin
            o_min <= i_sample;
            o_max <= i_sample;
        end else if (i_update) begin
            if (i_sample < o_min) begin
                o_min <= i_sample;
            end
            if (i_sample > o_max) begin
                o_max <= i_sample;
            end
        end
    end

endmodule

// File: rtl/channel_waveform_decoder.sv
// Receive-side waveform decoder: measures the frame-pulse period in clocks and
// the min/max sample excursion over each period, with lock and timeout flags.
module channel_waveform_decoder
    import channel_waveform_decoder_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = AUDIO_SAMPLE_WIDTH,
    parameter int PERIOD_WIDTH   = AUDIO_PERIOD_WIDTH,
    parameter int MAX_PERIOD     = 2**24 - 1,
    parameter int LOCK_TOLERANCE = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    input  logic                    i_frame_pulse,
    output logic [PERIOD_WIDTH-1:0] o_period,
    output logic [SAMPLE_WIDTH-1:0] o_min,
    output logic [SAMPLE_WIDTH-1:0] o_max,
    output logic [SAMPLE_WIDTH-1:0] o_amplitude,
    output logic                    o_valid,
    output logic                    o_locked,
    output logic                    o_timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam logic [PERIOD_WIDTH-1:0] MAX_COUNT = PERIOD_WIDTH'(MAX_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] LOCK_TOL  = PERIOD_WIDTH'(LOCK_TOLERANCE);
    localparam logic [PERIOD_WIDTH-1:0] COUNT_ONE = PERIOD_WIDTH'(1);

    logic [1:0]              state;
    logic                    frame_prev;
    logic [PERIOD_WIDTH-1:0] count;
    logic                    have_prev;
    logic                    pulse_edge;
    logic                    measuring;
    logic                    run_restart;
    logic                    run_update;
    logic [SAMPLE_WIDTH-1:0] run_min;
    logic [SAMPLE_WIDTH-1:0] run_max;
    logic [PERIOD_WIDTH-1:0] period_diff;
    logic                    within_tol;

    assign pulse_edge  = i_frame_pulse & ~frame_prev;
    assign measuring   = (state == ST_MEASURE);
    assign run_restart = pulse_edge & ~i_clear;
    assign run_update  = measuring & ~pulse_edge;

    assign period_diff = (count >= o_period) ? (count - o_period) : (o_period - count);
    assign within_tol  = (period_diff <= LOCK_TOL);

    channel_waveform_decoder_running_min_max #(
        .WIDTH (SAMPLE_WIDTH)
    ) u_running_min_max (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (run_restart),
        .i_update  (run_update),
        .i_sample  (i_sample),
        .o_min     (run_min),
        .o_max     (run_max)
    );

    // The edge sample opens the next period, so latching uses the running
    // values from before this cycle; an edge on the saturating count still wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            frame_prev  <= 1'b0;
            count       <= '0;
            have_prev   <= 1'b0;
            o_period    <= '0;
            o_min       <= '0;
            o_max       <= '0;
            o_amplitude <= '0;
            o_valid     <= 1'b0;
            o_locked    <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            frame_prev <= i_frame_pulse;
            o_valid    <= 1'b0;
            if (i_clear) begin
                state     <= ST_IDLE;
                have_prev <= 1'b0;
                o_locked  <= 1'b0;
                o_timeout <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_TIMEOUT: begin
                        if (pulse_edge) begin
                            state     <= ST_MEASURE;
                            count     <= COUNT_ONE;
                            o_timeout <= 1'b0;
                        end
                    end
                    ST_MEASURE: begin
                        if (pulse_edge) begin
                            o_period    <= count;
                            o_min       <= run_min;
                            o_max       <= run_max;
                            o_amplitude <= run_max - run_min;
                            o_valid     <= 1'b1;
                            o_locked    <= have_prev & within_tol;
                            have_prev   <= 1'b1;
                            count       <= COUNT_ONE;
                        end else if (count == MAX_COUNT) begin
                            state     <= ST_TIMEOUT;
                            have_prev <= 1'b0;
                            o_timeout <= 1'b1;
                            o_locked  <= 1'b0;
                        end else begin
                            count <= count + COUNT_ONE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_channel_waveform_decoder.sv
// Directed bench for channel_waveform_decoder: triangle lock, period change,
// timeout, edge at the period limit, clear-with-edge and asynchronous reset.
module tb_channel_waveform_decoder;

    localparam int SW   = 9;
    localparam int PW   = 24;
    localparam int MAXP = 100;
    localparam int TOL  = 1;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_clear = 1'b0;
    logic [SW-1:0] i_sample = '0;
    logic          i_frame_pulse = 1'b0;
    logic [PW-1:0] o_period;
    logic [SW-1:0] o_min;
    logic [SW-1:0] o_max;
    logic [SW-1:0] o_amplitude;
    logic          o_valid;
    logic          o_locked;
    logic          o_timeout;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] phase = '0;
    logic        gen_prev_pulse = 1'b0;

    channel_waveform_decoder #(
        .SAMPLE_WIDTH   (SW),
        .PERIOD_WIDTH   (PW),
        .MAX_PERIOD     (MAXP),
        .LOCK_TOLERANCE (TOL)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clear       (i_clear),
        .i_sample      (i_sample),
        .i_frame_pulse (i_frame_pulse),
        .o_period      (o_period),
        .o_min         (o_min),
        .o_max         (o_max),
        .o_amplitude   (o_amplitude),
        .o_valid       (o_valid),
        .o_locked      (o_locked),
        .o_timeout     (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic pulse, input logic [SW-1:0] sample, input logic clear);
        @(negedge i_clk);
        i_frame_pulse = pulse;
        i_sample      = sample;
        i_clear       = clear;
        @(posedge i_clk);
        #1;
    endtask

    task automatic gen_step(input logic [31:0] delta, output logic rising);
        logic [4:0]    p;
        logic [SW-1:0] s;
        p = phase[31:27];
        s = p[4] ? SW'(5'd31 - p) : SW'(p);
        rising = phase[31] & ~gen_prev_pulse;
        gen_prev_pulse = phase[31];
        drive(phase[31], s, 1'b0);
        phase = phase + delta;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        tests_run++; if (o_period !== '0) begin tests_failed++; $display("[TB] FAIL reset_period: got %0d expected 0", o_period); end
        tests_run++; if (o_min !== '0) begin tests_failed++; $display("[TB] FAIL reset_min: got %0d expected 0", o_min); end
        tests_run++; if (o_max !== '0) begin tests_failed++; $display("[TB] FAIL reset_max: got %0d expected 0", o_max); end
        tests_run++; if (o_amplitude !== '0) begin tests_failed++; $display("[TB] FAIL reset_amp: got %0d expected 0", o_amplitude); end
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
        tests_run++; if (o_locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_locked: got %b expected 0", o_locked); end
        tests_run++; if (o_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_timeout: got %b expected 0", o_timeout); end
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_triangle_lock();
        logic rising;
        logic exp_valid;
        int   edges;
        edges = 0;
        phase = '0;
        gen_prev_pulse = 1'b0;
        for (int i = 0; i < 200 && edges < 3; i++) begin
            gen_step(32'h0800_0000, rising);
            if (rising) edges++;
            exp_valid = rising && (edges >= 2);
            tests_run++; if (o_valid !== exp_valid) begin tests_failed++; $display("[TB] FAIL tri_valid step %0d: got %b expected %b", i, o_valid, exp_valid); end
            if (exp_valid) begin
                tests_run++; if (o_period !== PW'(32)) begin tests_failed++; $display("[TB] FAIL tri_period: got %0d expected 32", o_period); end
                tests_run++; if (o_min !== SW'(0)) begin tests_failed++; $display("[TB] FAIL tri_min: got %0d expected 0", o_min); end
                tests_run++; if (o_max !== SW'(15)) begin tests_failed++; $display("[TB] FAIL tri_max: got %0d expected 15", o_max); end
                tests_run++; if (o_amplitude !== SW'(15)) begin tests_failed++; $display("[TB] FAIL tri_amp: got %0d expected 15", o_amplitude); end
                tests_run++; if (o_locked !== (edges == 3)) begin tests_failed++; $display("[TB] FAIL tri_locked edge %0d: got %b expected %b", edges, o_locked, (edges == 3)); end
            end
        end
        tests_run++; if (edges != 3) begin tests_failed++; $display("[TB] FAIL tri_edges: got %0d expected 3", edges); end
    endtask

    task automatic test_period_change();
        logic          rising;
        int            results;
        logic [PW-1:0] exp_period [3];
        logic          exp_locked [3];
        exp_period = '{PW'(48), PW'(64), PW'(64)};
        exp_locked = '{1'b0, 1'b0, 1'b1};
        results = 0;
        for (int i = 0; i < 15; i++) begin
            gen_step(32'h0800_0000, rising);
            tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL chg_pre_valid step %0d: got %b expected 0", i, o_valid); end
        end
        for (int i = 0; i < 300 && results < 3; i++) begin
            gen_step(32'h0400_0000, rising);
            tests_run++; if (o_valid !== rising) begin tests_failed++; $display("[TB] FAIL chg_valid step %0d: got %b expected %b", i, o_valid, rising); end
            if (rising) begin
                tests_run++; if (o_period !== exp_period[results]) begin tests_failed++; $display("[TB] FAIL chg_period %0d: got %0d expected %0d", results, o_period, exp_period[results]); end
                tests_run++; if (o_locked !== exp_locked[results]) begin tests_failed++; $display("[TB] FAIL chg_locked %0d: got %b expected %b", results, o_locked, exp_locked[results]); end
                tests_run++; if (o_min !== SW'(0) || o_max !== SW'(15)) begin tests_failed++; $display("[TB] FAIL chg_minmax %0d: got %0d/%0d expected 0/15", results, o_min, o_max); end
                results++;
            end
        end
        tests_run++; if (results != 3) begin tests_failed++; $display("[TB] FAIL chg_results: got %0d expected 3", results); end
    endtask

    task automatic test_timeout();
        drive(1'b0, SW'(0), 1'b1);
        tests_run++; if (o_locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_clear_locked: got %b expected 0", o_locked); end
        drive(1'b0, SW'(0), 1'b0);
        drive(1'b1, SW'(200), 1'b0);
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_first_edge_valid: got %b expected 0", o_valid); end
        for (int j = 1; j <= 100; j++) begin
            drive(1'b0, SW'(9), 1'b0);
            tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_valid step %0d: got %b expected 0", j, o_valid); end
            tests_run++; if (o_timeout !== (j == 100)) begin tests_failed++; $display("[TB] FAIL to_timeout step %0d: got %b expected %b", j, o_timeout, (j == 100)); end
        end
        tests_run++; if (o_locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_locked: got %b expected 0", o_locked); end
        repeat (3) drive(1'b0, SW'(9), 1'b0);
        tests_run++; if (o_timeout !== 1'b1 || o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_hold: got timeout %b valid %b expected 1 0", o_timeout, o_valid); end
        drive(1'b1, SW'(200), 1'b0);
        tests_run++; if (o_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_edge_clears: got %b expected 0", o_timeout); end
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_edge_valid: got %b expected 0", o_valid); end
        drive(1'b0, SW'(7), 1'b0);
        drive(1'b0, SW'(300), 1'b0);
        repeat (7) drive(1'b0, SW'(100), 1'b0);
        drive(1'b1, SW'(500), 1'b0);
        tests_run++; if (o_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_after_valid: got %b expected 1", o_valid); end
        tests_run++; if (o_period !== PW'(10)) begin tests_failed++; $display("[TB] FAIL to_after_period: got %0d expected 10", o_period); end
        tests_run++; if (o_min !== SW'(7) || o_max !== SW'(300)) begin tests_failed++; $display("[TB] FAIL to_after_minmax: got %0d/%0d expected 7/300", o_min, o_max); end
        tests_run++; if (o_amplitude !== SW'(293)) begin tests_failed++; $display("[TB] FAIL to_after_amp: got %0d expected 293", o_amplitude); end
        tests_run++; if (o_locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_after_locked: got %b expected 0", o_locked); end
    endtask

    task automatic test_edge_at_max();
        for (int j = 1; j <= 99; j++) begin
            drive(1'b0, SW'(20), 1'b0);
            tests_run++; if (o_valid !== 1'b0 || o_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL max_wait step %0d: got valid %b timeout %b expected 0 0", j, o_valid, o_timeout); end
        end
        drive(1'b1, SW'(1), 1'b0);
        tests_run++; if (o_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL max_valid: got %b expected 1", o_valid); end
        tests_run++; if (o_period !== PW'(100)) begin tests_failed++; $display("[TB] FAIL max_period: got %0d expected 100", o_period); end
        tests_run++; if (o_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL max_timeout: got %b expected 0", o_timeout); end
        tests_run++; if (o_min !== SW'(20) || o_max !== SW'(500)) begin tests_failed++; $display("[TB] FAIL max_minmax: got %0d/%0d expected 20/500", o_min, o_max); end
        tests_run++; if (o_amplitude !== SW'(480)) begin tests_failed++; $display("[TB] FAIL max_amp: got %0d expected 480", o_amplitude); end
        drive(1'b0, SW'(33), 1'b0);
        tests_run++; if (o_timeout !== 1'b0 || o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL max_after: got timeout %b valid %b expected 0 0", o_timeout, o_valid); end
    endtask

    task automatic test_clear_with_edge();
        repeat (6) drive(1'b0, SW'(33), 1'b0);
        drive(1'b1, SW'(33), 1'b0);
        tests_run++; if (o_valid !== 1'b1 || o_period !== PW'(8)) begin tests_failed++; $display("[TB] FAIL clr_setup1: got valid %b period %0d expected 1 8", o_valid, o_period); end
        tests_run++; if (o_min !== SW'(1) || o_max !== SW'(33) || o_locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_setup1_vals: got %0d/%0d locked %b expected 1/33 0", o_min, o_max, o_locked); end
        repeat (7) drive(1'b0, SW'(33), 1'b0);
        drive(1'b1, SW'(33), 1'b0);
        tests_run++; if (o_valid !== 1'b1 || o_locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL clr_setup2: got valid %b locked %b expected 1 1", o_valid, o_locked); end
        repeat (7) drive(1'b0, SW'(33), 1'b0);
        drive(1'b1, SW'(99), 1'b1);
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_valid: got %b expected 0", o_valid); end
        tests_run++; if (o_locked !== 1'b0 || o_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_flags: got locked %b timeout %b expected 0 0", o_locked, o_timeout); end
        tests_run++; if (o_period !== PW'(8)) begin tests_failed++; $display("[TB] FAIL clr_period_hold: got %0d expected 8", o_period); end
        tests_run++; if (o_min !== SW'(33) || o_max !== SW'(33) || o_amplitude !== SW'(0)) begin tests_failed++; $display("[TB] FAIL clr_result_hold: got %0d/%0d/%0d expected 33/33/0", o_min, o_max, o_amplitude); end
        drive(1'b0, SW'(99), 1'b0);
        drive(1'b1, SW'(60), 1'b0);
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_idle_edge: got %b expected 0", o_valid); end
        repeat (4) drive(1'b0, SW'(70), 1'b0);
        drive(1'b1, SW'(5), 1'b0);
        tests_run++; if (o_valid !== 1'b1 || o_period !== PW'(5)) begin tests_failed++; $display("[TB] FAIL clr_next_result: got valid %b period %0d expected 1 5", o_valid, o_period); end
        tests_run++; if (o_min !== SW'(60) || o_max !== SW'(70) || o_amplitude !== SW'(10)) begin tests_failed++; $display("[TB] FAIL clr_next_vals: got %0d/%0d/%0d expected 60/70/10", o_min, o_max, o_amplitude); end
        tests_run++; if (o_locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_next_locked: got %b expected 0", o_locked); end
    endtask

    task automatic test_async_reset();
        repeat (2) drive(1'b0, SW'(3), 1'b0);
        @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        #1;
        tests_run++; if (o_period !== '0 || o_min !== '0 || o_max !== '0 || o_amplitude !== '0) begin tests_failed++; $display("[TB] FAIL arst_results: got %0d %0d %0d %0d expected all 0", o_period, o_min, o_max, o_amplitude); end
        tests_run++; if (o_valid !== 1'b0 || o_locked !== 1'b0 || o_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_flags: got %b %b %b expected 0 0 0", o_valid, o_locked, o_timeout); end
        @(negedge i_clk);
        i_frame_pulse = 1'b1;
        i_sample      = SW'(45);
        #2;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_first_edge: got %b expected 0", o_valid); end
        for (int j = 1; j <= 6; j++) begin
            drive(1'b0, SW'(40), 1'b0);
            tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_wait step %0d: got %b expected 0", j, o_valid); end
        end
        drive(1'b1, SW'(41), 1'b0);
        tests_run++; if (o_valid !== 1'b1 || o_period !== PW'(7)) begin tests_failed++; $display("[TB] FAIL arst_second_edge: got valid %b period %0d expected 1 7", o_valid, o_period); end
        tests_run++; if (o_min !== SW'(40) || o_max !== SW'(45) || o_amplitude !== SW'(5)) begin tests_failed++; $display("[TB] FAIL arst_vals: got %0d/%0d/%0d expected 40/45/5", o_min, o_max, o_amplitude); end
        tests_run++; if (o_locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_locked: got %b expected 0", o_locked); end
    endtask

    initial begin
        test_reset();
        test_triangle_lock();
        test_period_change();
        test_timeout();
        test_edge_at_max();
        test_clear_with_edge();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: still running at %0t, expected completion well before", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
